// File: rtl/leve1_ifetch_prefetch.sv
// leve1_ifetch_prefetch
//   Sequential instruction prefetcher. Issues in-order 32-bit AXI reads ahead
//   of the core, buffers returned instructions in a small FIFO and presents
//   them to ID on a valid/ready handshake. A redirect from EX flushes the FIFO
//   and arranges for every read still in flight to be discarded on return.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   REDIR_WE/REDIR_PC   redirect strobe and 4-byte aligned target from EX
//   ARVALID/ARREADY/ARADDR       AXI read address channel
//   RVALID/RREADY/RDATA/RRESP    AXI read data channel
//   IF_VALID/IF_READY            handoff handshake to ID
//   IF_PC/IF_INSTR/IF_FAULT      presented instruction, its PC and error flag
module leve1_ifetch_prefetch #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REDIR_WE,
   input  logic [XLEN-1:0] REDIR_PC,
   output logic            ARVALID,
   input  logic            ARREADY,
   output logic [XLEN-1:0] ARADDR,
   input  logic            RVALID,
   output logic            RREADY,
   input  logic [31:0]     RDATA,
   input  logic [1:0]      RRESP,
   output logic            IF_VALID,
   input  logic            IF_READY,
   output logic [XLEN-1:0] IF_PC,
   output logic [31:0]     IF_INSTR,
   output logic            IF_FAULT
);

   localparam int PW = $clog2(DEPTH);
   // Stale reads are not bounded by DEPTH (each redirect may strand up to a
   // full window), so the in-flight counters carry a few spare bits.
   localparam int CW = PW + 4;
   localparam int EW = XLEN + 33;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [XLEN-1:0] INC     = XLEN'(4);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

   state_t          state;
   logic [XLEN-1:0] fetch_pc;      // next address to request
   logic [XLEN-1:0] exp_pc;        // PC of the next live beat to be pushed
   logic [CW-1:0]   outstanding;   // all accepted ARs without an R beat yet
   logic [CW-1:0]   drop_cnt;      // how many of those are stale
   logic [CW-1:0]   count;         // FIFO occupancy
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [EW-1:0]   mem [DEPTH];

   logic            ar_hs, r_hs, pop, push, drop_beat, stall;
   logic [CW-1:0]   out_n, drop_n, cnt_n;
   logic [XLEN-1:0] fpc_n;
   logic            credit_ok;
   logic [EW-1:0]   push_word;

   assign ar_hs     = ARVALID & ARREADY;
   assign r_hs      = RVALID & RREADY;
   assign pop       = IF_VALID & IF_READY;
   assign drop_beat = r_hs & (drop_cnt != '0);
   // A live beat landing in a redirect cycle belongs to the old stream.
   assign push      = r_hs & (drop_cnt == '0) & ~REDIR_WE;
   assign stall     = ARVALID & ~ARREADY;
   assign out_n     = outstanding + CW'(ar_hs) - CW'(r_hs);
   assign push_word = {exp_pc, RDATA, |RRESP};

   always_comb begin
      drop_n = drop_cnt;
      cnt_n  = count;
      fpc_n  = fetch_pc;
      if (REDIR_WE) begin
         // Everything still in flight after this edge (including an AR
         // accepted on this very edge) belongs to the old stream.
         drop_n = out_n;
         cnt_n  = '0;
         fpc_n  = REDIR_PC;
      end else begin
         // In HOLD the address being handed over is a pre-redirect one.
         drop_n = drop_cnt - CW'(drop_beat) + CW'((state == S_HOLD) && ar_hs);
         cnt_n  = count + CW'(push) - CW'(pop);
         if (state == S_FETCH && ar_hs)
            fpc_n = fetch_pc + INC;
      end
      // Live reads plus buffered entries must never exceed FIFO capacity, so
      // RREADY can stay high unconditionally.
      credit_ok = (cnt_n + out_n - drop_n) < DEPTH_C;
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= S_IDLE;
         fetch_pc    <= RESET_PC;
         exp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         ARVALID     <= 1'b0;
         ARADDR      <= RESET_PC;
         RREADY      <= 1'b0;
         IF_VALID    <= 1'b0;
         IF_PC       <= '0;
         IF_INSTR    <= '0;
         IF_FAULT    <= 1'b0;
      end else begin
         outstanding <= out_n;
         drop_cnt    <= drop_n;
         count       <= cnt_n;
         fetch_pc    <= fpc_n;
         IF_VALID    <= (cnt_n != '0);

         if (REDIR_WE) begin
            exp_pc <= REDIR_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) begin
               exp_pc <= exp_pc + INC;
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            // Output registers mirror the FIFO head: advance to the next
            // stored entry on a pop, or take the incoming beat when it is
            // about to become the only entry.
            if (pop && count > CW'(1))
               {IF_PC, IF_INSTR, IF_FAULT} <= mem[rd_ptr + PW'(1)];
            else if (push && cnt_n == CW'(1))
               {IF_PC, IF_INSTR, IF_FAULT} <= push_word;
         end

         case (state)
            S_IDLE: begin
               state   <= S_FETCH;
               RREADY  <= 1'b1;
               ARVALID <= credit_ok;
               ARADDR  <= fpc_n;
            end
            S_FETCH: begin
               if (stall) begin
                  // AR must stay put until accepted; remember the redirect.
                  if (REDIR_WE)
                     state <= S_HOLD;
               end else begin
                  ARVALID <= credit_ok;
                  ARADDR  <= fpc_n;
               end
            end
            S_HOLD: begin
               if (ar_hs) begin
                  state   <= S_FETCH;
                  ARVALID <= credit_ok;
                  ARADDR  <= fpc_n;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
